// File: rtl/uart_tx_fifo_param_if.sv
// Word handshake into the UART transmitter: producer drives data/valid, the
// transmitter answers with ready while its FIFO has room.
interface uart_tx_fifo_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_i;
   logic                 valid_i;
   logic                 ready_o;

   modport master (output data_i, output valid_i, input ready_o);
   modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO: start bit, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits; queued words go out back-to-back.
module uart_tx_fifo_param #(
   parameter int  FREQUENCY  = 50_000_000,
   parameter int  SPEED      = 1_500_000,
   parameter int  DATA_BITS  = 8,
   parameter int  PARITY     = 0,
   parameter int  STOP_BITS  = 1,
   parameter int  FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   uart_tx_fifo_param_if.slave s_if,
   output logic                tx_o,
   output logic                busy_o,
   output logic [AW:0]         fifo_count_o
);

   localparam int DIVIDER = FREQUENCY / SPEED;
   localparam int TW      = $clog2(DIVIDER);
   localparam int BW      = $clog2(DATA_BITS);
   localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);

   localparam logic [TW-1:0] TICK_LAST = TW'(DIVIDER - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Odd parity inverts the payload XOR; anything else uses the plain XOR.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
      return (PARITY == 1) ? ~(^w) : (^w);
   endfunction

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 r_ready;

   state_t               r_state;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;
   logic                 r_busy;

   state_t               w_state_nxt;
   logic [TW-1:0]        w_tick_nxt;
   logic [BW-1:0]        w_bit_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_par_nxt;
   logic                 w_tx_nxt;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_tick_end;
   logic [DATA_BITS-1:0] w_head;
   logic [AW:0]          w_count_nxt;

   assign w_push     = s_if.valid_i & r_ready;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_tick_end = (r_tick == TICK_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      if (r_state != S_IDLE) begin
         w_tick_nxt = w_tick_end ? '0 : r_tick + TICK_ONE;
      end
      case (r_state)
         S_IDLE: begin
            w_tick_nxt = '0;
            w_tx_nxt   = 1'b1;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
               w_shift_nxt = w_head;
               w_par_nxt   = parity_of(w_head);
               w_bit_nxt   = '0;
               w_tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (w_tick_end) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
               w_tx_nxt    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_tick_end) begin
               if (r_bit == BIT_LAST) begin
                  w_bit_nxt = '0;
                  if (HAS_PAR) begin
                     w_state_nxt = S_PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_bit_nxt   = r_bit + BIT_ONE;
                  w_shift_nxt = r_shift >> 1;
                  w_tx_nxt    = r_shift[1];
               end
            end
         end
         S_PARITY: begin
            if (w_tick_end) begin
               w_state_nxt = S_STOP;
               w_bit_nxt   = '0;
               w_tx_nxt    = 1'b1;
            end
         end
         S_STOP: begin
            if (w_tick_end) begin
               if (r_bit == STOP_LAST) begin
                  w_bit_nxt = '0;
                  // Chain straight into the next start bit when a word is waiting.
                  if (r_count != '0) begin
                     w_pop       = 1'b1;
                     w_state_nxt = S_START;
                     w_shift_nxt = w_head;
                     w_par_nxt   = parity_of(w_head);
                     w_tx_nxt    = 1'b0;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_bit_nxt = r_bit + BIT_ONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b1;
         r_state  <= S_IDLE;
         r_tick   <= '0;
         r_bit    <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_count  <= w_count_nxt;
         r_ready  <= (w_count_nxt != CNT_FULL);
         r_state  <= w_state_nxt;
         r_tick   <= w_tick_nxt;
         r_bit    <= w_bit_nxt;
         r_tx     <= w_tx_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= s_if.data_i;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
   end

   assign s_if.ready_o = r_ready;
   assign tx_o         = r_tx;
   assign busy_o       = r_busy;
   assign fifo_count_o = r_count;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param at DIVIDER=8: four instances cover
// 8N1, 8E1, 8O1 and 7N2 framing, FIFO back-pressure, reset and data holding.
module tb_uart_tx_fifo_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_fifo_param_if #(.DATA_BITS(8)) ifa ();
   uart_tx_fifo_param_if #(.DATA_BITS(8)) ifb ();
   uart_tx_fifo_param_if #(.DATA_BITS(8)) ifc ();
   uart_tx_fifo_param_if #(.DATA_BITS(7)) ifd ();

   logic [3:0] tx_s;
   logic [3:0] busy_s;
   logic [2:0] cnt_s [4];

   uart_tx_fifo_param #(.FREQUENCY(8), .SPEED(1), .DATA_BITS(8), .PARITY(0),
                        .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk_i(clk), .reset_i(rst), .s_if(ifa.slave),
      .tx_o(tx_s[0]), .busy_o(busy_s[0]), .fifo_count_o(cnt_s[0]));
   uart_tx_fifo_param #(.FREQUENCY(8), .SPEED(1), .DATA_BITS(8), .PARITY(2),
                        .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
      .clk_i(clk), .reset_i(rst), .s_if(ifb.slave),
      .tx_o(tx_s[1]), .busy_o(busy_s[1]), .fifo_count_o(cnt_s[1]));
   uart_tx_fifo_param #(.FREQUENCY(8), .SPEED(1), .DATA_BITS(8), .PARITY(1),
                        .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
      .clk_i(clk), .reset_i(rst), .s_if(ifc.slave),
      .tx_o(tx_s[2]), .busy_o(busy_s[2]), .fifo_count_o(cnt_s[2]));
   uart_tx_fifo_param #(.FREQUENCY(8), .SPEED(1), .DATA_BITS(7), .PARITY(0),
                        .STOP_BITS(2), .FIFO_DEPTH(4)) dut_d (
      .clk_i(clk), .reset_i(rst), .s_if(ifd.slave),
      .tx_o(tx_s[3]), .busy_o(busy_s[3]), .fifo_count_o(cnt_s[3]));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_fall(input int inst, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_s[inst] === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Called on the first negedge of the start bit; samples every clock of the frame.
   task automatic rx_frame(input int inst, input int nbits, output logic [15:0] bits,
                           output int glitches, output int busy_n);
      bits = '0;
      glitches = 0;
      busy_n = 0;
      for (int b = 0; b < nbits; b++) begin
         bits[b] = tx_s[inst];
         if (busy_s[inst] === 1'b1) busy_n++;
         for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (tx_s[inst] !== bits[b]) glitches++;
            if (busy_s[inst] === 1'b1) busy_n++;
         end
         @(negedge clk);
      end
   endtask

   logic [15:0] bits, bits3;
   int          gl, bn, gl3, bn3, lows, highs;
   logic        ok, ok3;
   logic [7:0]  w3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifa.data_i = '0; ifa.valid_i = 1'b0;
      ifb.data_i = '0; ifb.valid_i = 1'b0;
      ifc.data_i = '0; ifc.valid_i = 1'b0;
      ifd.data_i = '0; ifd.valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_s[0], 1);
      check("rst_busy", busy_s[0], 0);
      check("rst_ready", ifa.ready_o, 1);
      check("rst_cnt", cnt_s[0], 0);
      rst = 1'b0;
      @(negedge clk);

      // 8N1, single word 0x55
      ifa.data_i = 8'h55; ifa.valid_i = 1'b1;
      @(negedge clk);
      ifa.valid_i = 1'b0;
      check("t1_cnt_after_push", cnt_s[0], 1);
      check("t1_tx_still_high", tx_s[0], 1);
      @(negedge clk);
      check("t1_tx_fell", tx_s[0], 0);
      check("t1_cnt_popped", cnt_s[0], 0);
      rx_frame(0, 10, bits, gl, bn);
      check("t1_frame", bits, 32'h2AA);
      check("t1_glitch", gl, 0);
      check("t1_busy80", bn, 80);
      check("t1_busy_end", busy_s[0], 0);
      check("t1_idle_tx", tx_s[0], 1);

      // 8E1 and 8O1 with 0x55 (four ones -> even bit 0, odd bit 1)
      ifb.data_i = 8'h55; ifb.valid_i = 1'b1;
      @(negedge clk);
      ifb.valid_i = 1'b0;
      wait_fall(1, 4, ok);
      check("t2e_start", ok, 1);
      rx_frame(1, 11, bits, gl, bn);
      check("t2e_frame", bits, 32'h4AA);
      check("t2e_busy88", bn, 88);
      check("t2e_busy_end", busy_s[1], 0);
      ifc.data_i = 8'h55; ifc.valid_i = 1'b1;
      @(negedge clk);
      ifc.valid_i = 1'b0;
      wait_fall(2, 4, ok);
      check("t2o_start", ok, 1);
      rx_frame(2, 11, bits, gl, bn);
      check("t2o_frame", bits, 32'h6AA);
      check("t2o_busy88", bn, 88);
      check("t2o_glitch", gl, 0);

      // 7N2 with 0x41
      ifd.data_i = 7'h41; ifd.valid_i = 1'b1;
      @(negedge clk);
      ifd.valid_i = 1'b0;
      wait_fall(3, 4, ok);
      check("t4_start", ok, 1);
      rx_frame(3, 10, bits, gl, bn);
      check("t4_frame", bits, 32'h382);
      check("t4_busy80", bn, 80);
      check("t4_glitch", gl, 0);
      check("t4_busy_end", busy_s[3], 0);

      // Six pushes on consecutive clocks into a depth-4 FIFO
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               if (i == 4) check("t3_ready_before5", ifa.ready_o, 1);
               if (i == 5) begin
                  check("t3_ready_low6", ifa.ready_o, 0);
                  check("t3_cnt_full", cnt_s[0], 4);
               end
               ifa.data_i = w3[i]; ifa.valid_i = 1'b1;
               @(negedge clk);
            end
            ifa.valid_i = 1'b0;
            check("t3_cnt_after6", cnt_s[0], 4);
         end
         begin
            wait_fall(0, 10, ok3);
            check("t3_start", ok3, 1);
            for (int f = 0; f < 5; f++) begin
               rx_frame(0, 10, bits3, gl3, bn3);
               check($sformatf("t3_frame%0d", f), bits3, {22'd0, 1'b1, w3[f], 1'b0});
               check($sformatf("t3_busy%0d", f), bn3, 80);
            end
         end
      join
      check("t3_busy_end", busy_s[0], 0);
      check("t3_cnt_end", cnt_s[0], 0);
      lows = 0;
      repeat (30) begin
         if (tx_s[0] !== 1'b1) lows++;
         @(negedge clk);
      end
      check("t3_no_sixth", lows, 0);

      // Reset during DATA with two words queued
      ifa.data_i = 8'h00; ifa.valid_i = 1'b1;
      @(negedge clk);
      ifa.data_i = 8'hA5;
      @(negedge clk);
      ifa.data_i = 8'h5A;
      @(negedge clk);
      ifa.valid_i = 1'b0;
      repeat (14) @(negedge clk);
      check("t5_pre_tx", tx_s[0], 0);
      check("t5_pre_cnt", cnt_s[0], 2);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_tx", tx_s[0], 1);
      check("t5_rst_cnt", cnt_s[0], 0);
      check("t5_rst_ready", ifa.ready_o, 1);
      check("t5_rst_busy", busy_s[0], 0);
      @(negedge clk);
      rst = 1'b0;
      lows = 0; highs = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_s[0] !== 1'b1) lows++;
         if (busy_s[0] !== 1'b0) highs++;
      end
      check("t5_no_frames", lows, 0);
      check("t5_no_busy", highs, 0);

      // Data changes after acceptance must not affect the frame
      ifa.data_i = 8'hC3; ifa.valid_i = 1'b1;
      @(negedge clk);
      ifa.valid_i = 1'b0;
      ifa.data_i = 8'h3C;
      wait_fall(0, 4, ok);
      check("t6_start", ok, 1);
      check("t6_cnt_mid", cnt_s[0], 0);
      ifa.data_i = 8'hFF;
      rx_frame(0, 10, bits, gl, bn);
      check("t6_frame", bits, 32'h386);
      check("t6_cnt_end", cnt_s[0], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
